// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The slave view belongs to the loader and the master view to the host that feeds it.
interface imem_boot_loader_if #(
    parameter int INSTRUCTION_LEN      = 16,
    parameter int INSTRUCTION_MEM_SIZE = 8
);
    localparam int AW = (INSTRUCTION_MEM_SIZE > 1) ? $clog2(INSTRUCTION_MEM_SIZE) : 1;

    logic [7:0]                 in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic                       imem_we;
    logic [AW-1:0]              imem_addr;
    logic [INSTRUCTION_LEN-1:0] imem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Packs a valid/ready byte stream into instruction words, writes them to instruction memory and
// holds the processor in reset until the image is loaded. Define IMEM_CHECKSUM_EN for XOR-checked images.
module imem_boot_loader #(
    parameter int INSTRUCTION_LEN      = 16,
    parameter int INSTRUCTION_MEM_SIZE = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reload,
    imem_boot_loader_if.slave        bus,
    output logic                     cpu_reset,
    output logic                     done,
    output logic                     err
);
    localparam int BPW = INSTRUCTION_LEN / 8;
    localparam int AW  = (INSTRUCTION_MEM_SIZE > 1) ? $clog2(INSTRUCTION_MEM_SIZE) : 1;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [AW-1:0] LAST_WORD = AW'(INSTRUCTION_MEM_SIZE - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(BPW - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
`ifdef IMEM_CHECKSUM_EN
        CHECK = 3'd3,
        ERROR = 3'd5,
`endif
        RUN   = 3'd4
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [AW-1:0]              word_cnt;
    logic [BW-1:0]              byte_cnt;
    logic [INSTRUCTION_LEN-1:0] word;
    logic [INSTRUCTION_LEN-1:0] word_shift;
    logic [AW-1:0]              addr_q;
    logic [INSTRUCTION_LEN-1:0] wdata_q;
    logic                       cpu_reset_q;
    logic                       done_q;
    logic                       byte_acc;
    logic                       last_byte;
    logic                       restart;
    logic                       in_ready_c;
    logic                       imem_we_c;
`ifdef IMEM_CHECKSUM_EN
    logic [7:0]                 csum;
    logic                       err_q;
`endif

    // Concatenate then truncate so a one-byte word (BPW == 1) needs no special case.
    function automatic logic [INSTRUCTION_LEN-1:0] shift_in(
        input logic [INSTRUCTION_LEN-1:0] w,
        input logic [7:0]                 b
    );
        logic [INSTRUCTION_LEN+7:0] cat;
        cat = {w, b};
        return cat[INSTRUCTION_LEN-1:0];
    endfunction

    assign byte_acc   = (state == LOAD) && bus.in_valid;
    assign last_byte  = (byte_cnt == LAST_BYTE);
    assign word_shift = shift_in(word, bus.in_data);

    always_comb begin
        state_next = state;
        in_ready_c = 1'b0;
        imem_we_c  = 1'b0;
        restart    = 1'b0;
        case (state)
            IDLE: state_next = LOAD;
            LOAD: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && last_byte) state_next = WRITE;
            end
            WRITE: begin
                imem_we_c = 1'b1;
                if (word_cnt == LAST_WORD) begin
`ifdef IMEM_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = RUN;
`endif
                end else begin
                    state_next = LOAD;
                end
            end
`ifdef IMEM_CHECKSUM_EN
            CHECK: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_next = (bus.in_data == csum) ? RUN : ERROR;
            end
            ERROR: begin
                if (reload) begin
                    restart    = 1'b1;
                    state_next = LOAD;
                end
            end
`endif
            RUN: begin
                if (reload) begin
                    restart    = 1'b1;
                    state_next = LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control: state and registered processor-facing status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cpu_reset_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_next;
            cpu_reset_q <= (state_next == RUN);
            done_q      <= (state_next == RUN);
        end
    end

`ifdef IMEM_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
            csum  <= 8'h00;
        end else begin
            err_q <= (state_next == ERROR);
            if (restart)       csum <= 8'h00;
            else if (byte_acc) csum <= csum ^ bus.in_data;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Datapath: byte packing, word counter and held write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt <= '0;
            byte_cnt <= '0;
            word     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (restart) begin
            word_cnt <= '0;
            byte_cnt <= '0;
            word     <= '0;
        end else begin
            if (byte_acc) begin
                word <= word_shift;
                if (last_byte) begin
                    byte_cnt <= '0;
                    addr_q   <= word_cnt;
                    wdata_q  <= word_shift;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
            // The final word leaves word_cnt parked; only reload or reset rewinds it.
            if ((state == WRITE) && (word_cnt != LAST_WORD)) word_cnt <= word_cnt + 1'b1;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.imem_we    = imem_we_c;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_reset      = cpu_reset_q;
    assign done           = done_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: reset, continuous and gapped loads, reload, mid-load reset,
// and the checksum accept/reject paths when IMEM_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_imem_boot_loader;
    localparam int ILEN  = 16;
    localparam int MSIZE = 8;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic reload = 1'b0;
    logic cpu_reset;
    logic done;
    logic err;

    imem_boot_loader_if #(.INSTRUCTION_LEN(ILEN), .INSTRUCTION_MEM_SIZE(MSIZE)) bus ();

    imem_boot_loader #(.INSTRUCTION_LEN(ILEN), .INSTRUCTION_MEM_SIZE(MSIZE)) dut (
        .clk       (clk),
        .reset     (reset),
        .reload    (reload),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int          n_checks   = 0;
    int          n_errors   = 0;
    int          ready_viol = 0;
    logic [7:0]  img   [16];
    logic [15:0] exp_w [8];
    logic [2:0]  wq_addr [$];
    logic [15:0] wq_data [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wq_addr.push_back(bus.imem_addr);
            wq_data.push_back(bus.imem_wdata);
            if (bus.in_ready) ready_viol++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic load_image(input int max_gap, input int reload_at);
        for (int i = 0; i < 16; i++) begin
            if (i == reload_at) begin
                bus.in_valid = 1'b0;
                reload = 1'b1;
                @(negedge clk);
                reload = 1'b0;
            end
            send_byte(img[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
        bus.in_valid = 1'b0;
    endtask

    // Entered on the negedge of the final WRITE cycle.
    task automatic finish_run(input string tag);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 16; i++) x = x ^ img[i];
        chk({tag, "_we_last"}, bus.imem_we, 1);
        chk({tag, "_addr_last"}, bus.imem_addr, 7);
        chk({tag, "_rdy_write"}, bus.in_ready, 0);
        chk({tag, "_cpu_held"}, cpu_reset, 0);
`ifdef IMEM_CHECKSUM_EN
        @(negedge clk);
        chk({tag, "_rdy_check"}, bus.in_ready, 1);
        send_byte(x, 0);
        bus.in_valid = 1'b0;
`else
        @(negedge clk);
`endif
        chk({tag, "_cpu_run"}, cpu_reset, 1);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_rdy_run"}, bus.in_ready, 0);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, wq_addr.size(), 8);
        for (int i = 0; i < 8 && i < wq_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wq_addr[i], i);
            chk($sformatf("%s_data%0d", tag, i), wq_data[i], exp_w[i]);
        end
        wq_addr.delete();
        wq_data.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        // Reset: everything low, then one IDLE cycle before in_ready.
        #20;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_we", bus.imem_we, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_cpu", cpu_reset, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        #30;
        reset = 1'b1;
        #1;
        chk("idle_rdy", bus.in_ready, 0);
        @(negedge clk);
        chk("load_rdy", bus.in_ready, 1);

        // Continuous stream.
        img   = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
                  8'h0F, 8'hED, 8'hCB, 8'hA9, 8'h87, 8'h65, 8'h43, 8'h21};
        exp_w = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0FED, 16'hCBA9, 16'h8765, 16'h4321};
        load_image(0, -1);
        finish_run("cont");
        check_writes("cont");
        chk("hold_we", bus.imem_we, 0);
        chk("hold_addr", bus.imem_addr, 7);
        chk("hold_wdata", bus.imem_wdata, 16'h4321);

        // RUN refuses bytes.
        bus.in_data  = 8'hEE;
        bus.in_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("run_rdy", bus.in_ready, 0);
        chk("run_done", done, 1);
        chk("run_nowr", wq_addr.size(), 0);

        // Reload from RUN.
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_cpu", cpu_reset, 0);
        chk("reload_done", done, 0);
        chk("reload_rdy", bus.in_ready, 1);

        // Gapped stream, with a reload pulse during a WRITE cycle that must be ignored.
        load_image(3, 6);
        finish_run("gap");
        check_writes("gap");
        chk("rdy_during_we", ready_viol, 0);

        // Reset after 5 bytes of a new load.
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(img[i], 0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_cpu", cpu_reset, 0);
        chk("midrst_rdy", bus.in_ready, 0);
        chk("midrst_addr", bus.imem_addr, 0);
        wq_addr.delete();
        wq_data.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_nowr", wq_addr.size(), 0);
        img   = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'hF0, 8'h0F, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_w = '{16'hA55A, 16'hC33C, 16'h0102, 16'h0304, 16'hF00F, 16'h1122, 16'h3344, 16'h5566};
        load_image(1, -1);
        finish_run("after_rst");
        check_writes("after_rst");

`ifdef IMEM_CHECKSUM_EN
        // Image 0x01..0x10 has XOR 0x10; a checksum of 0x11 must be rejected.
        img   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                  8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};
        exp_w = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C, 16'h0D0E, 16'h0F10};
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        load_image(0, -1);
        @(negedge clk);
        chk("bad_rdy_check", bus.in_ready, 1);
        send_byte(8'h11, 0);
        bus.in_valid = 1'b0;
        chk("bad_err", err, 1);
        chk("bad_cpu", cpu_reset, 0);
        chk("bad_done", done, 0);
        chk("bad_rdy", bus.in_ready, 0);
        check_writes("bad");
        repeat (3) @(negedge clk);
        chk("bad_err_stays", err, 1);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("bad_reload_err", err, 0);
        chk("bad_reload_rdy", bus.in_ready, 1);
        load_image(0, -1);
        chk("good_xor_src", img[15], 8'h10);
        finish_run("good");
        check_writes("good");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
